// File: rtl/collision_engine.sv
// collision_engine: per-frame collision judge for the STG core.
// Each frame it tests the player against the boss hitbox, then scans every
// bullet slot in the bullet RAM, one slot per cycle. It reports the first hit,
// keeps a lifetime hit count and applies invulnerability frames after a hit.
// Optional feature macro: COLLISION_GRAZE_EN adds a wrapping graze counter.
module collision_engine #(
  parameter int W        = 10,
  parameter int N_BUL    = 32,
  parameter int IDX_W    = 5,
  parameter int HIT_R2   = 60,
  parameter int BOX_XL   = 11,
  parameter int BOX_XR   = 12,
  parameter int BOX_YT   = 19,
  parameter int BOX_YB   = 20,
  parameter int IFRAMES  = 60,
  parameter int GRAZE_R2 = 400
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [W-1:0]     i_player_x,
  input  logic [W-1:0]     i_player_y,
  input  logic [W-1:0]     i_boss_x,
  input  logic [W-1:0]     i_boss_y,
  output logic [IDX_W-1:0] o_bul_idx,
  input  logic [W-1:0]     i_bul_x,
  input  logic [W-1:0]     i_bul_y,
  input  logic             i_bul_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_collision,
  output logic [IDX_W:0]   o_hit_idx,
  output logic [7:0]       o_hit_count,
  output logic             o_invuln,
  output logic [15:0]      o_graze_cnt
);

  localparam int BW    = W + 2;
  localparam int D2W   = 2 * W + 3;
  localparam int INV_W = (IFRAMES < 1) ? 1 : $clog2(IFRAMES + 1);

  localparam logic signed [BW-1:0] C_XL = BW'(BOX_XL);
  localparam logic signed [BW-1:0] C_XR = BW'(BOX_XR);
  localparam logic signed [BW-1:0] C_YT = BW'(BOX_YT);
  localparam logic signed [BW-1:0] C_YB = BW'(BOX_YB);
  localparam logic [D2W-1:0]       C_R2 = D2W'(HIT_R2);
  localparam logic [IDX_W:0]       C_N  = (IDX_W + 1)'(N_BUL);
  localparam logic [INV_W-1:0]     C_IF = INV_W'(IFRAMES);

  typedef enum logic [1:0] {IDLE, BOX, SCAN, DONE} state_t;

  state_t           r_state;
  logic [W-1:0]     r_px, r_py, r_bx, r_by;
  logic [IDX_W:0]   r_k;
  logic             r_found;
  logic [IDX_W:0]   r_first;
  logic             r_shield;
  logic [INV_W-1:0] r_inv;
  logic             r_busy, r_done, r_collision;
  logic [IDX_W:0]   r_hit_idx;
  logic [7:0]       r_hit_count;

  logic signed [BW-1:0]  w_px_s, w_py_s, w_bx_s, w_by_s;
  logic                  w_box_hit;
  logic signed [W:0]     w_dx, w_dy;
  logic signed [2*W+1:0] w_dx2, w_dy2;
  logic [D2W-1:0]        w_d2;
  logic                  w_eval;
  logic                  w_slot_hit;
  logic [IDX_W-1:0]      w_slot;

  // Boss box test in widened signed arithmetic so edges near 0 never wrap.
  always_comb begin
    w_px_s    = $signed({2'b00, r_px});
    w_py_s    = $signed({2'b00, r_py});
    w_bx_s    = $signed({2'b00, r_bx});
    w_by_s    = $signed({2'b00, r_by});
    w_box_hit = (w_px_s >= w_bx_s - C_XL) && (w_px_s < w_bx_s + C_XR) &&
                (w_py_s >= w_by_s - C_YT) && (w_py_s < w_by_s + C_YB);
  end

  // Circle test on the slot returned by the RAM for the previous address.
  always_comb begin
    w_dx       = $signed({1'b0, r_px}) - $signed({1'b0, i_bul_x});
    w_dy       = $signed({1'b0, r_py}) - $signed({1'b0, i_bul_y});
    w_dx2      = w_dx * w_dx;
    w_dy2      = w_dy * w_dy;
    w_d2       = {1'b0, w_dx2} + {1'b0, w_dy2};
    w_eval     = (r_state == SCAN) && (r_k != '0) && i_bul_valid;
    w_slot_hit = w_eval && (w_d2 < C_R2);
    w_slot     = r_k[IDX_W-1:0] - IDX_W'(1);
  end

  // Frame sequencer: latch positions, box test, slot scan, then report.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_px        <= '0;
      r_py        <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_k         <= '0;
      r_found     <= 1'b0;
      r_first     <= '0;
      r_shield    <= 1'b0;
      r_inv       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_collision <= 1'b0;
      r_hit_idx   <= '0;
      r_hit_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done      <= 1'b0;
          r_collision <= 1'b0;
          if (i_start) begin
            r_px     <= i_player_x;
            r_py     <= i_player_y;
            r_bx     <= i_boss_x;
            r_by     <= i_boss_y;
            r_k      <= '0;
            r_found  <= 1'b0;
            r_first  <= '0;
            r_busy   <= 1'b1;
            r_shield <= (r_inv != '0);
            if (r_inv != '0) r_inv <= r_inv - 1'b1;
            r_state  <= BOX;
          end
        end
        BOX: begin
          if (w_box_hit) begin
            r_found <= 1'b1;
            r_first <= {1'b1, {IDX_W{1'b0}}};
          end
          r_state <= SCAN;
        end
        SCAN: begin
          if (w_slot_hit && !r_found) begin
            r_found <= 1'b1;
            r_first <= {1'b0, w_slot};
          end
          if (r_k == C_N) begin
            r_k     <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
            if ((r_found || w_slot_hit) && !r_shield) begin
              r_collision <= 1'b1;
              r_hit_idx   <= r_found ? r_first : {1'b0, w_slot};
              if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
              r_inv       <= C_IF;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          r_done      <= 1'b0;
          r_collision <= 1'b0;
          r_busy      <= 1'b0;
          r_shield    <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef COLLISION_GRAZE_EN
  localparam logic [D2W-1:0] C_GR2 = D2W'(GRAZE_R2);
  logic [15:0] r_graze_cnt;
  logic        w_graze;

  // A live slot inside the graze ring but outside the hit radius grazes.
  always_comb begin
    w_graze = w_eval && (w_d2 >= C_R2) && (w_d2 < C_GR2);
  end

  // Wrapping graze counter, independent of invulnerability.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_graze_cnt <= '0;
    else if (w_graze) r_graze_cnt <= r_graze_cnt + 16'd1;
  end

  assign o_graze_cnt = r_graze_cnt;
`else
  assign o_graze_cnt = 16'd0;
`endif

  assign o_bul_idx   = r_k[IDX_W-1:0];
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_collision = r_collision;
  assign o_hit_idx   = r_hit_idx;
  assign o_hit_count = r_hit_count;
  assign o_invuln    = (r_inv != '0) || (r_busy && r_shield);

endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine with a small synchronous bullet RAM model.
module tb_collision_engine;

  localparam int W     = 10;
  localparam int N_BUL = 16;
  localparam int IDX_W = 4;
  localparam int LAT   = N_BUL + 3;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [W-1:0]     i_player_x = '0, i_player_y = '0, i_boss_x = '0, i_boss_y = '0;
  logic [IDX_W-1:0] o_bul_idx;
  logic [W-1:0]     i_bul_x, i_bul_y;
  logic             i_bul_valid;
  logic             o_busy, o_done, o_collision, o_invuln;
  logic [IDX_W:0]   o_hit_idx;
  logic [7:0]       o_hit_count;
  logic [15:0]      o_graze_cnt;

  logic [W-1:0] mem_x [N_BUL];
  logic [W-1:0] mem_y [N_BUL];
  logic         mem_v [N_BUL];

  int total = 0;
  int bad   = 0;

  bit   f_done;
  int   f_lat;
  logic f_col, f_inv;

  collision_engine #(.W(W), .N_BUL(N_BUL), .IDX_W(IDX_W), .IFRAMES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_player_x(i_player_x), .i_player_y(i_player_y),
    .i_boss_x(i_boss_x), .i_boss_y(i_boss_y),
    .o_bul_idx(o_bul_idx), .i_bul_x(i_bul_x), .i_bul_y(i_bul_y),
    .i_bul_valid(i_bul_valid), .o_busy(o_busy), .o_done(o_done),
    .o_collision(o_collision), .o_hit_idx(o_hit_idx),
    .o_hit_count(o_hit_count), .o_invuln(o_invuln), .o_graze_cnt(o_graze_cnt)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  // Synchronous bullet RAM: data follows the address by one cycle.
  always @(posedge i_clk) begin
    i_bul_x     <= mem_x[o_bul_idx];
    i_bul_y     <= mem_y[o_bul_idx];
    i_bul_valid <= mem_v[o_bul_idx];
  end

  task automatic clear_mem();
    for (int i = 0; i < N_BUL; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
      mem_v[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    i_start = 1'b0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic set_pos(input int px, input int py, input int bx, input int by);
    i_player_x = W'(px);
    i_player_y = W'(py);
    i_boss_x   = W'(bx);
    i_boss_y   = W'(by);
  endtask

  // Pulses start, waits (bounded) for done and captures the frame report.
  task automatic run_frame();
    f_done = 1'b0;
    f_lat  = 0;
    f_col  = 1'b0;
    f_inv  = 1'b0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 1; c <= 100 && !f_done; c++) begin
      if (o_done === 1'b1) begin
        f_done = 1'b1;
        f_lat  = c;
        f_col  = o_collision;
        f_inv  = o_invuln;
      end else begin
        @(negedge i_clk);
      end
    end
    if (!f_done) begin
      total++;
      bad++;
      $display("[TB] FAIL frame_timeout: done never seen within 100 cycles");
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_busy, o_done, o_collision, o_invuln} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {o_busy, o_done, o_collision, o_invuln});
    end
    total++;
    if ({o_hit_idx, o_hit_count, o_graze_cnt, o_bul_idx} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_values: hit_idx=%0d hit_count=%0d graze=%0d bul_idx=%0d expected all 0",
               o_hit_idx, o_hit_count, o_graze_cnt, o_bul_idx);
    end
    do_reset();
  endtask

  task automatic test_boss_overlap();
    do_reset();
    clear_mem();
    set_pos(100, 100, 111, 100);
    run_frame();
    total++;
    if (f_lat !== LAT) begin
      bad++;
      $display("[TB] FAIL boss_latency: got %0d expected %0d", f_lat, LAT);
    end
    total++;
    if (f_col !== 1'b1) begin
      bad++;
      $display("[TB] FAIL boss_collision: got %b expected 1", f_col);
    end
    total++;
    if (o_hit_idx !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL boss_hit_idx: got %b expected 10000", o_hit_idx);
    end
    total++;
    if (o_hit_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL boss_hit_count: got %0d expected 1", o_hit_count);
    end
  endtask

  task automatic test_box_edge();
    do_reset();
    clear_mem();
    set_pos(112, 100, 100, 100);
    run_frame();
    total++;
    if (f_col !== 1'b0) begin
      bad++;
      $display("[TB] FAIL box_right_edge: got %b expected 0", f_col);
    end
    set_pos(89, 100, 100, 100);
    run_frame();
    total++;
    if (f_col !== 1'b1) begin
      bad++;
      $display("[TB] FAIL box_left_edge: got %b expected 1", f_col);
    end
    do_reset();
    set_pos(1000, 1000, 5, 5);
    run_frame();
    total++;
    if (f_col !== 1'b0) begin
      bad++;
      $display("[TB] FAIL box_no_wrap: got %b expected 0", f_col);
    end
  endtask

  task automatic test_circle();
    do_reset();
    clear_mem();
    set_pos(500, 500, 100, 100);
    mem_x[7] = 10'd507; mem_y[7] = 10'd503; mem_v[7] = 1'b1;
    run_frame();
    total++;
    if (f_col !== 1'b1 || o_hit_idx !== 5'd7) begin
      bad++;
      $display("[TB] FAIL circle_d2_58: col=%b hit_idx=%0d expected col=1 hit_idx=7", f_col, o_hit_idx);
    end
    do_reset();
    clear_mem();
    mem_x[3] = 10'd503; mem_y[3] = 10'd507; mem_v[3] = 1'b1;
    mem_x[9] = 10'd495; mem_y[9] = 10'd495; mem_v[9] = 1'b1;
    run_frame();
    total++;
    if (f_col !== 1'b1 || o_hit_idx !== 5'd3) begin
      bad++;
      $display("[TB] FAIL circle_priority: col=%b hit_idx=%0d expected col=1 hit_idx=3", f_col, o_hit_idx);
    end
    do_reset();
    clear_mem();
    mem_x[4] = 10'd505; mem_y[4] = 10'd494; mem_v[4] = 1'b1;
    run_frame();
    total++;
    if (f_col !== 1'b0) begin
      bad++;
      $display("[TB] FAIL circle_d2_61: got %b expected 0", f_col);
    end
    clear_mem();
    mem_x[7] = 10'd507; mem_y[7] = 10'd503; mem_v[7] = 1'b0;
    run_frame();
    total++;
    if (f_col !== 1'b0) begin
      bad++;
      $display("[TB] FAIL circle_invalid: got %b expected 0", f_col);
    end
    mem_x[15] = 10'd499; mem_y[15] = 10'd500; mem_v[15] = 1'b1;
    run_frame();
    total++;
    if (f_col !== 1'b1 || o_hit_idx !== 5'd15) begin
      bad++;
      $display("[TB] FAIL circle_last_slot: col=%b hit_idx=%0d expected col=1 hit_idx=15", f_col, o_hit_idx);
    end
  endtask

  task automatic test_iframes();
    logic [3:0] cols;
    logic [3:0] invs;
    do_reset();
    clear_mem();
    set_pos(100, 100, 111, 100);
    for (int f = 0; f < 4; f++) begin
      run_frame();
      cols[f] = f_col;
      invs[f] = f_inv;
    end
    total++;
    if (cols !== 4'b1001) begin
      bad++;
      $display("[TB] FAIL iframes_collision: frames4..1=%b expected 1001", cols);
    end
    total++;
    if (invs[2:1] !== 2'b11) begin
      bad++;
      $display("[TB] FAIL iframes_invuln: frames3..2=%b expected 11", invs[2:1]);
    end
    total++;
    if (o_hit_count !== 8'd2) begin
      bad++;
      $display("[TB] FAIL iframes_hit_count: got %0d expected 2", o_hit_count);
    end
  endtask

  task automatic test_control();
    int ndone;
    bit seen;
    do_reset();
    clear_mem();
    set_pos(500, 500, 100, 100);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    ndone = 0;
    repeat (60) begin
      if (o_done === 1'b1) ndone++;
      @(negedge i_clk);
    end
    total++;
    if (ndone !== 1) begin
      bad++;
      $display("[TB] FAIL start_while_busy: done count %0d expected 1", ndone);
    end
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (o_done === 1'b1) seen = 1'b1;
      else @(negedge i_clk);
    end
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    total++;
    if (!seen || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_with_done: done_seen=%b busy=%b expected done_seen=1 busy=0", seen, o_busy);
    end
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (8) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_busy, o_done, o_collision, o_bul_idx, o_hit_count} !== '0) begin
      bad++;
      $display("[TB] FAIL midscan_reset: busy=%b done=%b col=%b bul_idx=%0d count=%0d expected all 0",
               o_busy, o_done, o_collision, o_bul_idx, o_hit_count);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("[TB] FAIL midscan_no_done: done count %0d expected 0", ndone);
    end
    run_frame();
    total++;
    if (f_lat !== LAT) begin
      bad++;
      $display("[TB] FAIL restart_latency: got %0d expected %0d", f_lat, LAT);
    end
  endtask

  task automatic test_graze();
    do_reset();
    clear_mem();
    set_pos(500, 500, 100, 100);
    mem_x[2] = 10'd510; mem_y[2] = 10'd500; mem_v[2] = 1'b1;
    mem_x[5] = 10'd519; mem_y[5] = 10'd506; mem_v[5] = 1'b1;
    mem_x[6] = 10'd520; mem_y[6] = 10'd500; mem_v[6] = 1'b1;
    run_frame();
    total++;
    if (f_col !== 1'b0) begin
      bad++;
      $display("[TB] FAIL graze_collision: got %b expected 0", f_col);
    end
`ifdef COLLISION_GRAZE_EN
    total++;
    if (o_graze_cnt !== 16'd2) begin
      bad++;
      $display("[TB] FAIL graze_count: got %0d expected 2", o_graze_cnt);
    end
`else
    total++;
    if (o_graze_cnt !== 16'd0) begin
      bad++;
      $display("[TB] FAIL graze_tied_off: got %0d expected 0", o_graze_cnt);
    end
`endif
  endtask

  // Test sequence.
  initial begin
    clear_mem();
    test_reset();
    test_boss_overlap();
    test_box_edge();
    test_circle();
    test_iframes();
    test_control();
    test_graze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
